// File: rtl/sparce_mem_initiator_pkg.sv
// sparce_mem_initiator_pkg: op encoding, lane geometry and request legality shared by the sparse-memory initiator
package sparce_mem_initiator_pkg;
`ifdef DATA_WIDTH_32
  localparam int DW = 32;
`else
  localparam int DW = 64;
`endif
  localparam int BC = DW / 8;
  localparam int BADDR = $clog2(BC);
  typedef enum logic [2:0] {NOP, BYTE_OP, HALF_OP, WORD_OP, DWORD_OP} op_e;
  function automatic logic [3:0] op_bytes(op_e op);
    return op == BYTE_OP ? 4'd1 : op == HALF_OP ? 4'd2 : op == WORD_OP ? 4'd4 :
           op == DWORD_OP ? 4'd8 : 4'd0;
  endfunction
  function automatic logic op_legal(op_e op, logic [2:0] lo);
    logic [3:0] n;
    n = op_bytes(op);
    return n != 4'd0 && !(op == DWORD_OP && DW == 32) && (lo & (n[2:0] - 3'd1)) == 3'd0;
  endfunction
endpackage

// File: rtl/sparce_mem_if.sv
// sparce_mem_if: single-cycle cs/we/re bus between initiator and sparse memory model
interface sparce_mem_if
  import sparce_mem_initiator_pkg::*;
#(parameter int AW = 32);
  logic          cs;
  op_e           we;
  op_e           re;
  logic [AW-1:0] write_address;
  logic [AW-1:0] read_address;
  logic [DW-1:0] write_data;
  logic [DW-1:0] read_data;
  modport initiator(output cs, we, re, write_address, read_address, write_data, input read_data);
  modport target(input cs, we, re, write_address, read_address, write_data, output read_data);
endinterface

// File: rtl/sparce_lane_align.sv
// sparce_lane_align: store lane shift (LOAD=0) or load lane extract with zero/sign extension (LOAD=1)
module sparce_lane_align
  import sparce_mem_initiator_pkg::*;
#(
  parameter int W    = 64,
  parameter bit LOAD = 1'b0
) (
  input  logic [W-1:0]           i_data,
  input  op_e                    i_op,
  input  logic [$clog2(W/8)-1:0] i_lo,
  input  logic                   i_sgn,
  output logic [W-1:0]           o_data
);
  logic [W-1:0] w_mask, w_shr, w_val;
  logic         w_neg;
  // the top bit of the op mask selects the sign bit of the extracted value
  always_comb begin
    w_mask = ~({W{1'b1}} << {op_bytes(i_op), 3'b000});
    w_shr  = LOAD ? i_data >> {i_lo, 3'b000} : i_data;
    w_val  = w_shr & w_mask;
    w_neg  = i_sgn && |(w_val & (w_mask ^ (w_mask >> 1)));
    o_data = LOAD ? (w_val | (w_neg ? ~w_mask : '0)) : w_val << {i_lo, 3'b000};
  end
endmodule

// File: rtl/sparce_mem_initiator.sv
// sparce_mem_initiator: turns a valid/ready load/store stream into single-cycle sparse-memory bus transactions
module sparce_mem_initiator
  import sparce_mem_initiator_pkg::*;
#(parameter int AW = 32) (
  input  logic          clk,
  input  logic          nrst,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic          req_write,
  input  op_e           req_op,
  input  logic          req_signed,
  input  logic [AW-1:0] req_addr,
  input  logic [DW-1:0] req_wdata,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic [DW-1:0] rsp_rdata,
  output logic          rsp_err,
  sparce_mem_if.initiator mem_if
);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_e;
  state_e           r_state;
  logic             r_write, r_signed;
  op_e              r_op;
  logic [BADDR-1:0] r_lo;
  logic [DW-1:0]    w_wdata, w_rdata;
  logic             w_legal;
  assign w_legal = op_legal(req_op, req_addr[2:0]);
  sparce_lane_align #(.W(DW), .LOAD(1'b0)) u_store (
    .i_data(req_wdata), .i_op(req_op), .i_lo(req_addr[BADDR-1:0]), .i_sgn(1'b0), .o_data(w_wdata)
  );
  sparce_lane_align #(.W(DW), .LOAD(1'b1)) u_load (
    .i_data(mem_if.read_data), .i_op(r_op), .i_lo(r_lo), .i_sgn(r_signed), .o_data(w_rdata)
  );
  // bus enables are registered at the accept edge so cs is high exactly during ISSUE
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_state              <= IDLE;
      r_write              <= 1'b0;
      r_signed             <= 1'b0;
      r_op                 <= NOP;
      r_lo                 <= '0;
      req_ready            <= 1'b0;
      rsp_valid            <= 1'b0;
      rsp_rdata            <= '0;
      rsp_err              <= 1'b0;
      mem_if.cs            <= 1'b0;
      mem_if.we            <= NOP;
      mem_if.re            <= NOP;
      mem_if.write_address <= '0;
      mem_if.read_address  <= '0;
      mem_if.write_data    <= '0;
    end else begin
      mem_if.cs <= 1'b0;
      mem_if.we <= NOP;
      mem_if.re <= NOP;
      case (r_state)
        IDLE: begin
          req_ready <= !(req_valid && req_ready);
          if (req_valid && req_ready) begin
            r_write  <= req_write;
            r_signed <= req_signed;
            r_op     <= req_op;
            r_lo     <= req_addr[BADDR-1:0];
            if (w_legal) begin
              r_state   <= ISSUE;
              mem_if.cs <= 1'b1;
              if (req_write) begin
                mem_if.we            <= req_op;
                mem_if.write_address <= req_addr;
                mem_if.write_data    <= w_wdata;
              end else begin
                mem_if.re           <= req_op;
                mem_if.read_address <= req_addr;
              end
            end else begin
              r_state   <= RESP;
              rsp_valid <= 1'b1;
              rsp_err   <= 1'b1;
              rsp_rdata <= '0;
            end
          end
        end
        ISSUE: begin
          r_state   <= r_write ? RESP : WAIT;
          rsp_valid <= r_write;
          rsp_err   <= 1'b0;
          rsp_rdata <= '0;
        end
        WAIT: begin
          r_state   <= RESP;
          rsp_valid <= 1'b1;
          rsp_rdata <= w_rdata;
        end
        RESP: begin
          if (rsp_ready) begin
            r_state   <= IDLE;
            rsp_valid <= 1'b0;
            req_ready <= 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_sparce_mem_initiator.sv
// tb_sparce_mem_initiator: directed vectors against a small byte-array memory target
module tb_sparce_mem_initiator;
  import sparce_mem_initiator_pkg::*;
  localparam logic [63:0] M = DW == 64 ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
  logic          clk = 1'b0;
  logic          nrst = 1'b0;
  logic          req_valid = 1'b0, req_ready, req_write = 1'b0, req_signed = 1'b0;
  op_e           req_op = NOP;
  logic [31:0]   req_addr = '0;
  logic [DW-1:0] req_wdata = '0;
  logic          rsp_valid, rsp_ready = 1'b1, rsp_err;
  logic [DW-1:0] rsp_rdata;
  int            n_chk = 0, n_pass = 0, n_cs = 0;
  op_e           last_we = NOP, last_re = NOP;
  logic [DW-1:0] last_wdata = '0;
  logic [31:0]   last_addr = '0;
  logic [7:0]    mem [0:1023];
  sparce_mem_if mif ();
  sparce_mem_initiator dut (
    .clk(clk), .nrst(nrst), .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_op(req_op), .req_signed(req_signed), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .mem_if(mif)
  );
  always #5 clk = ~clk;
  int            wb, rb, lo, nb;
  logic [DW-1:0] rd_word;
  always @(posedge clk) begin
    if (mif.cs) begin
      n_cs++;
      last_we    = mif.we;
      last_re    = mif.re;
      last_wdata = mif.write_data;
      last_addr  = mif.we != NOP ? mif.write_address : mif.read_address;
      if (mif.we != NOP) begin
        wb = int'(mif.write_address[9:0]) & ~(BC - 1);
        lo = int'(mif.write_address[9:0]) & (BC - 1);
        nb = int'(op_bytes(mif.we));
        for (int b = 0; b < BC; b++)
          if (b >= lo && b < lo + nb) mem[wb + b] = mif.write_data[8*b +: 8];
      end
      if (mif.re != NOP) begin
        rb = int'(mif.read_address[9:0]) & ~(BC - 1);
        for (int b = 0; b < BC; b++) rd_word[8*b +: 8] = mem[rb + b];
        mif.read_data <= rd_word;
      end
    end
  end
  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h want %h", tag, act, exp);
  endtask
  task automatic xact(input logic wr, input op_e op, input logic sg, input logic [31:0] addr,
                      input logic [DW-1:0] wd, output int lat, output logic [DW-1:0] rd,
                      output logic er, output int ncs);
    int c0, t;
    c0 = n_cs;
    req_valid = 1'b1; req_write = wr; req_op = op; req_signed = sg; req_addr = addr; req_wdata = wd;
    t = 0;
    while (!req_ready && t < 20) begin @(posedge clk); #1; t++; end
    @(posedge clk); #1;
    req_valid = 1'b0;
    lat = 1;
    while (!rsp_valid && lat < 20) begin @(posedge clk); #1; lat++; end
    rd = rsp_rdata;
    er = rsp_err;
    if (rsp_ready) begin @(posedge clk); #1; end
    ncs = n_cs - c0;
  endtask
  int            lat, ncs, c0;
  logic [DW-1:0] rd;
  logic          er;
  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 8'(i * 7 + 3);
    mif.read_data = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_ready", req_ready, 0);
    check("rst_valid", rsp_valid, 0);
    check("rst_cs", mif.cs, 0);
    nrst = 1'b1;
    @(posedge clk); #1;
    check("ready_up", req_ready, 1);
    xact(1, BYTE_OP, 0, 32'h13, 'hA5, lat, rd, er, ncs);
    check("sb_lat", lat, 2);
    check("sb_err", er, 0);
    check("sb_ncs", ncs, 1);
    check("sb_we", last_we, BYTE_OP);
    check("sb_re", last_re, NOP);
    check("sb_wdata", last_wdata, 64'h0000_0000_A500_0000);
    check("sb_addr", last_addr, 32'h13);
    xact(1, WORD_OP, 0, 32'h104, 'hDEADBEEF, lat, rd, er, ncs);
    check("sw_lat", lat, 2);
    check("sw_wdata", last_wdata, 64'hDEAD_BEEF_0000_0000 >> (DW == 64 ? 0 : 32));
    xact(0, WORD_OP, 1, 32'h104, '0, lat, rd, er, ncs);
    check("lws_lat", lat, 3);
    check("lws_data", rd, 64'hFFFF_FFFF_DEAD_BEEF & M);
    check("lws_err", er, 0);
    check("lws_re", last_re, WORD_OP);
    check("lws_we", last_we, NOP);
    xact(0, WORD_OP, 0, 32'h104, '0, lat, rd, er, ncs);
    check("lwu_data", rd, 64'h0000_0000_DEAD_BEEF);
    check("lwu_lat", lat, 3);
    xact(0, HALF_OP, 1, 32'h106, '0, lat, rd, er, ncs);
    check("lhs_data", rd, 64'hFFFF_FFFF_FFFF_DEAD & M);
    xact(0, BYTE_OP, 1, 32'h13, '0, lat, rd, er, ncs);
    check("lbs_data", rd, 64'hFFFF_FFFF_FFFF_FFA5 & M);
    xact(0, BYTE_OP, 0, 32'h13, '0, lat, rd, er, ncs);
    check("lbu_data", rd, 64'hA5);
    xact(0, HALF_OP, 0, 32'h101, '0, lat, rd, er, ncs);
    check("mis_lat", lat, 1);
    check("mis_err", er, 1);
    check("mis_data", rd, 0);
    check("mis_ncs", ncs, 0);
    xact(0, NOP, 0, 32'h100, '0, lat, rd, er, ncs);
    check("nop_err", er, 1);
    check("nop_data", rd, 0);
    check("nop_ncs", ncs, 0);
    rsp_ready = 1'b0;
    xact(0, WORD_OP, 0, 32'h104, '0, lat, rd, er, ncs);
    c0 = n_cs;
    req_valid = 1'b1; req_write = 1'b1; req_op = BYTE_OP; req_addr = 32'h300; req_wdata = 'h77;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check("bp_valid", rsp_valid, 1);
      check("bp_data", rsp_rdata, 64'hDEAD_BEEF);
      check("bp_ready", req_ready, 0);
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    check("bp_rel_valid", rsp_valid, 0);
    check("bp_rel_ready", req_ready, 1);
    check("bp_ncs", n_cs - c0, 0);
    req_valid = 1'b1; req_write = 1'b0; req_op = WORD_OP; req_signed = 1'b0; req_addr = 32'h104;
    @(posedge clk); #1;
    req_valid = 1'b0;
    check("rw_cs_issue", mif.cs, 1);
    @(posedge clk); #1;
    nrst = 1'b0;
    #1;
    check("rw_cs", mif.cs, 0);
    check("rw_re", mif.re, NOP);
    check("rw_valid", rsp_valid, 0);
    check("rw_ready", req_ready, 0);
    repeat (2) @(posedge clk);
    #1 nrst = 1'b1;
    c0 = n_cs;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check("rw_novalid", rsp_valid, 0);
    end
    check("rw_nocs", n_cs - c0, 0);
    xact(1, WORD_OP, 0, 32'h108, 'h12345678, lat, rd, er, ncs);
    check("pr_st_lat", lat, 2);
    check("pr_st_err", er, 0);
    xact(0, WORD_OP, 0, 32'h108, '0, lat, rd, er, ncs);
    check("pr_ld_lat", lat, 3);
    check("pr_ld_data", rd, 64'h1234_5678);
    xact(1, DWORD_OP, 0, 32'h200, DW'(64'h0123_4567_89AB_CDEF), lat, rd, er, ncs);
    check("dw_st_err", er, DW == 32);
    check("dw_st_lat", lat, DW == 64 ? 2 : 1);
    xact(0, DWORD_OP, 0, 32'h200, '0, lat, rd, er, ncs);
    check("dw_ld_err", er, DW == 32);
    check("dw_ld_data", rd, DW == 64 ? 64'h0123_4567_89AB_CDEF : 64'h0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
